// File: rtl/reuel_nand_pkg.sv
// reuel_nand_pkg
// Shared constants for the NAND-only 4-bit logic unit tile:
//   - WIDTH          operand/result width (the pin map fixes it at 4)
//   - OP_*           3-bit function select codes carried on uio_in[2:0]
//   - HOLD_BIT       uio_in bit that freezes the output registers
//   - RES_LSB, ZERO_BIT, PAR_BIT, VALID_BIT, PAD_BIT
//                    field positions inside uo_out
package reuel_nand_pkg;

  localparam int WIDTH = 4;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_BUFA = 3'b111;

  localparam int HOLD_BIT = 3;

  localparam int RES_LSB   = 0;
  localparam int ZERO_BIT  = 4;
  localparam int PAR_BIT   = 5;
  localparam int VALID_BIT = 6;
  localparam int PAD_BIT   = 7;

endpackage

// File: rtl/reuel_pandher_nand_nand2_cell.sv
// nand2_cell
// The single primitive every Boolean function in the tile is built from.
// Ports:
//   a, b : inputs
//   y    : ~(a & b)
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/reuel_pandher_nand.sv
// reuel_pandher_nand
// Tiny Tapeout user tile: a 4-bit logic unit whose eight functions are all
// built from nand2_cell instances. The selected result and its zero/parity
// flags are registered with one clock of latency.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   ena      : tile enable, 1 allows capture
//   ui_in    : [3:0] operand A, [7:4] operand B
//   uio_in   : [2:0] op select, [3] hold, [7:4] unused
//   uo_out   : [3:0] result, [4] zero, [5] parity (1 = odd), [6] valid, [7] 0
//   uio_out  : always 0
//   uio_oe   : always 0 (bidirectional pins are inputs)
//
// Output qualifier: valid is a sticky status bit, not a handshake. It rises
// on the first capture after reset and stays high until the next reset; there
// is no ready/back-pressure, capture happens whenever ena=1 and hold=0.
module reuel_pandher_nand
  import reuel_nand_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             hold;
  logic             capture;

  assign a       = ui_in[WIDTH-1:0];
  assign b       = ui_in[2*WIDTH-1:WIDTH];
  assign op      = uio_in[2:0];
  assign hold    = uio_in[HOLD_BIT];
  assign capture = ena & ~hold;

  // uio_in[7:4] carry no function on this tile.
  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in[7:4]};

  // Per-bit NAND network.
  logic [WIDTH-1:0] n_ab;    // NAND(a,b)
  logic [WIDTH-1:0] f_and;   // NAND(n_ab,n_ab)
  logic [WIDTH-1:0] n_a;     // NOT a
  logic [WIDTH-1:0] n_b;     // NOT b
  logic [WIDTH-1:0] f_or;    // NAND(~a,~b)
  logic [WIDTH-1:0] f_nor;   // NOT or
  logic [WIDTH-1:0] x_l;     // NAND(a, n_ab)
  logic [WIDTH-1:0] x_r;     // NAND(b, n_ab)
  logic [WIDTH-1:0] f_xor;   // NAND(x_l, x_r)
  logic [WIDTH-1:0] f_xnor;  // NOT xor
  logic [WIDTH-1:0] f_bufa;  // NOT NOT a

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand2_cell u_nab  (.a(a[i]),     .b(b[i]),     .y(n_ab[i]));
    nand2_cell u_and  (.a(n_ab[i]),  .b(n_ab[i]),  .y(f_and[i]));
    nand2_cell u_na   (.a(a[i]),     .b(a[i]),     .y(n_a[i]));
    nand2_cell u_nb   (.a(b[i]),     .b(b[i]),     .y(n_b[i]));
    nand2_cell u_or   (.a(n_a[i]),   .b(n_b[i]),   .y(f_or[i]));
    nand2_cell u_nor  (.a(f_or[i]),  .b(f_or[i]),  .y(f_nor[i]));
    // Classic 4-gate XOR sharing the first NAND with the NAND function.
    nand2_cell u_xl   (.a(a[i]),     .b(n_ab[i]),  .y(x_l[i]));
    nand2_cell u_xr   (.a(b[i]),     .b(n_ab[i]),  .y(x_r[i]));
    nand2_cell u_xor  (.a(x_l[i]),   .b(x_r[i]),   .y(f_xor[i]));
    nand2_cell u_xnor (.a(f_xor[i]), .b(f_xor[i]), .y(f_xnor[i]));
    nand2_cell u_bufa (.a(n_a[i]),   .b(n_a[i]),   .y(f_bufa[i]));
  end

  logic [WIDTH-1:0] f_sel;

  always_comb begin
    f_sel = '0;
    case (op)
      OP_NAND: f_sel = n_ab;
      OP_AND:  f_sel = f_and;
      OP_OR:   f_sel = f_or;
      OP_NOR:  f_sel = f_nor;
      OP_XOR:  f_sel = f_xor;
      OP_XNOR: f_sel = f_xnor;
      OP_NOTA: f_sel = n_a;
      OP_BUFA: f_sel = f_bufa;
      default: f_sel = '0;
    endcase
  end

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             parity_q;
  logic             valid_q;

  // Reset deliberately clears zero_q even though result_q is 0: the zero
  // flag only reports a real captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (capture) begin
      result_q <= f_sel;
      zero_q   <= (f_sel == '0);
      parity_q <= ^f_sel;
      valid_q  <= 1'b1;
    end
  end

  always_comb begin
    uo_out                          = '0;
    uo_out[RES_LSB +: WIDTH]        = result_q;
    uo_out[ZERO_BIT]                = zero_q;
    uo_out[PAR_BIT]                 = parity_q;
    uo_out[VALID_BIT]               = valid_q;
    uo_out[PAD_BIT]                 = 1'b0;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_reuel_pandher_nand.sv
module tb_reuel_pandher_nand;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reuel_pandher_nand dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state of the output registers.
  logic [3:0] m_res   = 4'h0;
  logic       m_zero  = 1'b0;
  logic       m_par   = 1'b0;
  logic       m_valid = 1'b0;

  function automatic logic [3:0] ref_fn(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    case (op)
      3'd0: ref_fn = ~(a & b);
      3'd1: ref_fn = a & b;
      3'd2: ref_fn = a | b;
      3'd3: ref_fn = ~(a | b);
      3'd4: ref_fn = a ^ b;
      3'd5: ref_fn = ~(a ^ b);
      3'd6: ref_fn = ~a;
      default: ref_fn = a;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Predict the effect of the next edge from the inputs now applied, push it,
  // take the edge, then pop and compare 1 time unit later.
  task automatic tick(input string tag);
    logic [3:0] f;
    logic [7:0] exp;
    if (rst) begin
      m_res = 4'h0; m_zero = 1'b0; m_par = 1'b0; m_valid = 1'b0;
    end else if (ena && !uio_in[3]) begin
      f = ref_fn(uio_in[2:0], ui_in[3:0], ui_in[7:4]);
      m_res = f; m_zero = (f == 4'h0); m_par = ^f; m_valid = 1'b1;
    end
    exp_q.push_back({1'b0, m_valid, m_par, m_zero, m_res});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (uo_out !== exp) begin
      errors++;
      $display("FAIL %s uo_out got %h expected %h", tag, uo_out, exp);
    end
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL %s_bidir uio_out %h uio_oe %h expected 00 00", tag, uio_out, uio_oe);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; ui_in = 8'hAC; uio_in = 8'h00;
    tick("reset0");
    tick("reset1");
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_const uo_out got %h expected 00", uo_out);
    end
  endtask

  task automatic test_nand();
    rst = 1'b0; ena = 1'b1; ui_in = 8'hAC; uio_in = 8'h00;
    tick("nand");
    checks++;
    if (uo_out !== 8'h67) begin
      errors++;
      $display("FAIL nand_const uo_out got %h expected 67", uo_out);
    end
  endtask

  task automatic test_all_ops();
    logic [3:0] tbl [8];
    tbl = '{4'h7, 4'h8, 4'hE, 4'h1, 4'h6, 4'h9, 4'h3, 4'hC};
    for (int op = 1; op < 8; op++) begin
      ui_in = 8'hAC; uio_in = {5'b0, 3'(op)};
      tick($sformatf("op%0d", op));
      checks++;
      if (uo_out[3:0] !== tbl[op]) begin
        errors++;
        $display("FAIL op%0d_result got %h expected %h", op, uo_out[3:0], tbl[op]);
      end
      if (op == 1) begin
        checks++;
        if (uo_out !== 8'h68) begin
          errors++;
          $display("FAIL and_full uo_out got %h expected 68", uo_out);
        end
      end
      if (op == 4) begin
        checks++;
        if (uo_out !== 8'h46) begin
          errors++;
          $display("FAIL xor_full uo_out got %h expected 46", uo_out);
        end
      end
    end
  endtask

  task automatic test_zero();
    ui_in = 8'h55; uio_in = 8'h04;
    tick("zero");
    checks++;
    if (uo_out !== 8'h50) begin
      errors++;
      $display("FAIL zero_const uo_out got %h expected 50", uo_out);
    end
  endtask

  task automatic test_hold_ena();
    ena = 1'b1; ui_in = 8'hAC; uio_in = 8'h00;
    tick("hold_setup");
    for (int i = 0; i < 3; i++) begin
      ui_in = 8'($urandom_range(0, 255));
      uio_in = {4'h0, 1'b1, 3'($urandom_range(0, 7))};
      tick("hold");
      checks++;
      if (uo_out !== 8'h67) begin
        errors++;
        $display("FAIL hold_const uo_out got %h expected 67", uo_out);
      end
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ui_in = 8'($urandom_range(0, 255));
      uio_in = {4'h0, 1'b0, 3'($urandom_range(0, 7))};
      tick("ena_low");
      checks++;
      if (uo_out !== 8'h67) begin
        errors++;
        $display("FAIL ena_const uo_out got %h expected 67", uo_out);
      end
    end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    ui_in = 8'hAC; uio_in = 8'h01;
    tick("mid_capture");
    rst = 1'b1; uio_in = 8'h00;
    tick("mid_reset");
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_const uo_out got %h expected 00", uo_out);
    end
    rst = 1'b0;
    tick("after_reset");
    checks++;
    if (uo_out !== 8'h67) begin
      errors++;
      $display("FAIL after_reset_const uo_out got %h expected 67", uo_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      rst    = ($urandom_range(0, 15) == 0);
      ena    = ($urandom_range(0, 3) != 0);
      ui_in  = 8'($urandom_range(0, 255));
      uio_in = 8'($urandom_range(0, 255));
      tick("random");
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_nand();
    test_all_ops();
    test_zero();
    test_hold_ena();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reuel_pandher_nand.md
Name: reuel_pandher_nand

Overview:
Tiny Tapeout user tile implementing a 4-bit NAND-only logic unit. Two 4-bit operands from `ui_in` are combined by one of eight Boolean functions selected on `uio_in`. Every function is built structurally from 2-input NAND cells. The result and its flags are registered and presented on `uo_out`. The tile sits directly under the TT harness; bidirectional pins are inputs only.

Parameters:
- WIDTH, 4, operand/result width; only 4 is supported by the pin map.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, synchronous, active-high. The harness-level wrapper drives it as the inverse of the TT `rst_n` pin.
- ena  in  1  tile enable; 1 = capture allowed.
- ui_in  in  8  [3:0] operand A, [7:4] operand B.
- uio_in  in  8  [2:0] op select, [3] hold, [7:4] ignored.
- uo_out  out  8  [3:0] result, [4] zero flag, [5] parity flag, [6] valid, [7] constant 0.
- uio_out  out  8  constant 8'h00.
- uio_oe  out  8  constant 8'h00 (all bidirectional pins are inputs).

Behaviour:
- Op encoding, combinational from A and B:
  - 000 NAND = ~(A&B)
  - 001 AND
  - 010 OR
  - 011 NOR
  - 100 XOR
  - 101 XNOR
  - 110 NOT A
  - 111 BUF A
- Functions are formed only from NAND2 instances, e.g.:
  - NOT = NAND(x,x)
  - OR = NAND(~A,~B)
  - XOR = 4-NAND form
  - The op mux may be behavioural.
- Capture condition: `ena`=1 and hold (`uio_in[3]`)=0 and `rst`=0.
  - Registers load: result ← f(A,B); zero ← (f==0); parity ← ^f (1 = odd); valid ← 1.
- Otherwise (`ena`=0 or hold=1): all registers keep their value.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on `uo_out` after edge N.
- Reset: when `rst`=1 at a clock edge, result=0, zero=0, parity=0, valid=0. Reset overrides capture, hold and `ena`, and takes effect mid-operation at the next edge.
- `uo_out[7]`, `uio_out` and `uio_oe` are 0 at all times, including during reset.
- `valid` stays 1 after its first capture until the next reset.
- Zero flag is the registered compare of the result, not the reset default (reset gives 0 even though the result is 0).
- No X propagation: every register is reset.

Decomposition:
- Package `reuel_nand_pkg`:
  - op-code localparams: OP_NAND, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_NOTA, OP_BUFA
  - WIDTH
  - `uo_out` bit-index constants: RES_LSB, ZERO_BIT, PAR_BIT, VALID_BIT
- Sub-module `nand2_cell` (a, b → y = ~(a&b)), instantiated per bit per gate via generate loops. The top holds the function network, op mux, flag logic and registers.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `ui_in`=0xAC, op=000 → `uo_out`=0x00, `uio_oe`=0x00, `uio_out`=0x00.
- NAND: `ui_in`=0xAC (A=0xC, B=0xA), `uio_in`=0x00, `ena`=1, one edge → `uo_out`=0x67 (result 7, parity 1, valid 1).
- All ops with A=0xC, B=0xA, checked one cycle after each op change → result field:
  - AND 0x8, OR 0xE, NOR 0x1, XOR 0x6, XNOR 0x9, NOTA 0x3, BUFA 0xC
  - Full `uo_out`: XOR 0x46, AND 0x68.
- Zero flag: `ui_in`=0x55, op=100 (XOR) → `uo_out`=0x50 (result 0, zero 1, parity 0, valid 1).
- Hold/ena: after the NAND capture (0x67), set `uio_in[3]`=1 and change `ui_in`/op for 3 cycles → `uo_out` stays 0x67. Repeat with hold=0, `ena`=0 → still 0x67.
- Reset mid-run: `rst`=1 for one edge while capturing → next `uo_out`=0x00. First capture after reset brings valid back to 1.
